// File: rtl/branch_tag_alloc.sv
// -----------------------------------------------------------------------------
// branch_tag_alloc
//
// Purpose:
//   This block sits in the decode stage. It hands out in-flight branch tags to
//   the branches in a decoded pair, and it stalls decode when there are not
//   enough free tags. It also keeps track of which live tag is older than
//   which, using an age matrix.
//
//   When the execute stage resolves a branch correctly, that tag is freed.
//   When it resolves a mispredict, the resolved tag and every younger live tag
//   are killed, and a one-cycle flush with the killed set follows on the next
//   cycle.
//
// Optional feature (macro BRANCH_TAG_STATS_EN):
//   When the macro is defined, two saturating 16-bit counters are added:
//     stall_cycles      - number of cycles in which stall was high
//     mispredict_count  - number of accepted (live-tag) mispredict resolves
//   When it is undefined, these ports and counters do not exist.
//
// Ports:
//   clk, rst                      clock (rising edge); async active-high reset
//   dec_valid1/2, is_branch1/2    decode slot valid / is-branch flags
//                                 (slot 1 is the older slot)
//   resolve_valid/tag/mispredict  branch resolution from the execute stage
//   stall                         comb: decode must hold the current pair
//   tag1/tag2, tag_valid1/2       comb: tags allocated this cycle (0 when the
//                                 matching valid is low)
//   inflight_mask                 reg: live tags
//   free_count                    reg: number of free tags
//   flush, kill_mask              reg: one-cycle pulse and killed set after a
//                                 mispredict
// -----------------------------------------------------------------------------
module branch_tag_alloc #(
  parameter int NUM_TAGS = 4,
  parameter int TAG_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid1,
  input  logic                dec_valid2,
  input  logic                is_branch1,
  input  logic                is_branch2,
  input  logic                resolve_valid,
  input  logic [TAG_W-1:0]    resolve_tag,
  input  logic                resolve_mispredict,
  output logic                stall,
  output logic [TAG_W-1:0]    tag1,
  output logic [TAG_W-1:0]    tag2,
  output logic                tag_valid1,
  output logic                tag_valid2,
  output logic [NUM_TAGS-1:0] inflight_mask,
  output logic [TAG_W:0]      free_count,
  output logic                flush,
  output logic [NUM_TAGS-1:0] kill_mask
`ifdef BRANCH_TAG_STATS_EN
  ,
  output logic [15:0]         stall_cycles,
  output logic [15:0]         mispredict_count
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_TAGS-1:0]               mask_reg;
  logic [NUM_TAGS-1:0]               mask_next;
  logic [TAG_W:0]                    free_count_reg;
  logic [TAG_W:0]                    free_count_next;
  logic                              flush_reg;
  logic [NUM_TAGS-1:0]               kill_mask_reg;
  // older_reg[i][j] = 1 : tag i was allocated before tag j (both live)
  logic [NUM_TAGS-1:0][NUM_TAGS-1:0] older_reg;
  logic [NUM_TAGS-1:0][NUM_TAGS-1:0] older_next;

  // ---------------------------------------------------------------------------
  // Requests and stall
  // ---------------------------------------------------------------------------
  logic            req1;
  logic            req2;
  logic [TAG_W+1:0] need_ext;
  logic            mispredict_cycle;

  assign req1     = dec_valid1 & is_branch1;
  assign req2     = dec_valid2 & is_branch2;
  assign need_ext = (TAG_W+2)'(req1) + (TAG_W+2)'(req2);

  // A mispredict in flight always stalls decode, even if the tag is not live.
  // This keeps decode from racing the flush.
  assign mispredict_cycle = resolve_valid & resolve_mispredict;

  assign stall = (need_ext > {1'b0, free_count_reg}) | mispredict_cycle;

  // ---------------------------------------------------------------------------
  // Free-tag search: the two lowest-index free tags of the registered mask.
  // Tags freed in this cycle are not visible here (no bypass).
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] first_free;
  logic [TAG_W-1:0] second_free;

  always_comb begin
    int found;
    first_free  = '0;
    second_free = '0;
    found       = 0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (!mask_reg[i]) begin
        if (found == 0) begin
          first_free = TAG_W'(i);
        end else if (found == 1) begin
          second_free = TAG_W'(i);
        end
        found = found + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag outputs
  //
  // When only slot 2 requests, it takes the lowest free tag. Allocation is
  // all-or-nothing, so if there is a stall, neither slot is given a tag.
  // ---------------------------------------------------------------------------
  always_comb begin
    tag_valid1 = req1 & ~stall;
    tag_valid2 = req2 & ~stall;
    tag1       = '0;
    tag2       = '0;
    if (tag_valid1) begin
      tag1 = first_free;
    end
    if (tag_valid2) begin
      tag2 = req1 ? second_free : first_free;
    end
  end

  // ---------------------------------------------------------------------------
  // One-hot decodes of the allocated tags and the resolved tag.
  //
  // The resolve decode is compared per index. This means an out-of-range tag
  // (possible when NUM_TAGS is not a power of two) simply matches nothing.
  // ---------------------------------------------------------------------------
  logic [NUM_TAGS-1:0] alloc1;
  logic [NUM_TAGS-1:0] alloc2;
  logic [NUM_TAGS-1:0] alloc_any;
  logic [NUM_TAGS-1:0] resolve_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_decode
      assign alloc1[gi]         = tag_valid1 & (tag1 == TAG_W'(gi));
      assign alloc2[gi]         = tag_valid2 & (tag2 == TAG_W'(gi));
      assign resolve_onehot[gi] = resolve_tag == TAG_W'(gi);
    end
  endgenerate

  assign alloc_any = alloc1 | alloc2;

  // ---------------------------------------------------------------------------
  // Resolve handling
  // ---------------------------------------------------------------------------
  logic                resolve_hit;
  logic                mis_accept;
  logic                cor_accept;
  logic [NUM_TAGS-1:0] resolve_row;
  logic [NUM_TAGS-1:0] kill_set;
  logic [NUM_TAGS-1:0] free_set;
  logic [NUM_TAGS-1:0] live_keep;

  assign resolve_hit = resolve_valid & |(resolve_onehot & mask_reg);
  assign mis_accept  = resolve_hit & resolve_mispredict;
  assign cor_accept  = resolve_hit & ~resolve_mispredict;

  // Row of the age matrix for the resolved tag: every tag younger than it.
  always_comb begin
    resolve_row = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (resolve_onehot[i]) begin
        resolve_row = resolve_row | older_reg[i];
      end
    end
  end

  assign kill_set  = resolve_onehot | (resolve_row & mask_reg);
  assign free_set  = mis_accept ? kill_set : (cor_accept ? resolve_onehot : '0);
  assign live_keep = mask_reg & ~free_set;

  // A tag freed this cycle can never be allocated in the same cycle, because
  // the allocator looks only at the registered mask.
  assign mask_next = live_keep | alloc_any;

  // ---------------------------------------------------------------------------
  // Age matrix next state, row by row.
  //   - A freshly allocated row starts empty. The only exception is that the
  //     slot 1 tag is marked older than the slot 2 tag of the same pair.
  //   - Any other row clears the columns that are freed this cycle. If the
  //     row's own tag is still live, it also becomes older than every tag
  //     allocated now.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_TAGS; gi++) begin : g_age_next
      logic [NUM_TAGS-1:0] row_keep;
      assign row_keep = older_reg[gi] & ~free_set & {NUM_TAGS{live_keep[gi]}};
      assign older_next[gi] = alloc_any[gi]
                            ? (alloc1[gi] ? alloc2 : '0)
                            : (row_keep | (alloc_any & {NUM_TAGS{live_keep[gi]}}));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Free count, computed from the next-state mask
  // ---------------------------------------------------------------------------
  logic [TAG_W:0] pop_next;

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      pop_next = pop_next + (TAG_W+1)'(mask_next[i]);
    end
  end

  assign free_count_next = (TAG_W+1)'(NUM_TAGS) - pop_next;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_reg       <= '0;
      free_count_reg <= (TAG_W+1)'(NUM_TAGS);
      older_reg      <= '0;
      flush_reg      <= 1'b0;
      kill_mask_reg  <= '0;
    end else begin
      mask_reg       <= mask_next;
      free_count_reg <= free_count_next;
      older_reg      <= older_next;
      flush_reg      <= mis_accept;
      kill_mask_reg  <= mis_accept ? kill_set : '0;
    end
  end

  assign inflight_mask = mask_reg;
  assign free_count    = free_count_reg;
  assign flush         = flush_reg;
  assign kill_mask     = kill_mask_reg;

`ifdef BRANCH_TAG_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cycles_reg;
  logic [15:0] mispredict_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (stall && (stall_cycles_reg != 16'hFFFF)) begin
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      end
      if (mis_accept && (mispredict_count_reg != 16'hFFFF)) begin
        mispredict_count_reg <= mispredict_count_reg + 16'd1;
      end
    end
  end

  assign stall_cycles     = stall_cycles_reg;
  assign mispredict_count = mispredict_count_reg;
`endif

endmodule

// File: tb/tb_branch_tag_alloc.sv
// -----------------------------------------------------------------------------
// tb_branch_tag_alloc
//
// Self-checking bench for branch_tag_alloc (NUM_TAGS=4).
//
// The reference model keeps a live flag and an allocation sequence number for
// each tag. "Younger" means a larger sequence number. Every cycle, the bench
// checks the combinational outputs against the model and the registered
// outputs against the model state.
// -----------------------------------------------------------------------------
module tb_branch_tag_alloc;

  localparam int NUM_TAGS = 4;
  localparam int TAG_W    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                dec_valid1, dec_valid2, is_branch1, is_branch2;
  logic                resolve_valid, resolve_mispredict;
  logic [TAG_W-1:0]    resolve_tag;
  logic                stall, tag_valid1, tag_valid2, flush;
  logic [TAG_W-1:0]    tag1, tag2;
  logic [NUM_TAGS-1:0] inflight_mask, kill_mask;
  logic [TAG_W:0]      free_count;
`ifdef BRANCH_TAG_STATS_EN
  logic [15:0]         stall_cycles, mispredict_count;
`endif

  always #5 clk = ~clk;

  branch_tag_alloc #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .dec_valid1(dec_valid1), .dec_valid2(dec_valid2),
    .is_branch1(is_branch1), .is_branch2(is_branch2),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .stall(stall), .tag1(tag1), .tag2(tag2),
    .tag_valid1(tag_valid1), .tag_valid2(tag_valid2),
    .inflight_mask(inflight_mask), .free_count(free_count),
    .flush(flush), .kill_mask(kill_mask)
`ifdef BRANCH_TAG_STATS_EN
    , .stall_cycles(stall_cycles), .mispredict_count(mispredict_count)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_live [NUM_TAGS];
  int unsigned m_seq  [NUM_TAGS];
  int unsigned m_ctr;
  bit          m_flush;
  logic [NUM_TAGS-1:0] m_kill;
  int unsigned m_stall_cnt, m_mis_cnt;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_TAGS; i++) begin
      m_live[i] = 1'b0;
      m_seq[i]  = 0;
    end
    m_ctr = 0; m_flush = 1'b0; m_kill = '0;
    m_stall_cnt = 0; m_mis_cnt = 0;
  endtask

  function automatic logic [NUM_TAGS-1:0] model_mask();
    logic [NUM_TAGS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_TAGS; i++) m[i] = m_live[i];
    return m;
  endfunction

  function automatic int model_free();
    int f;
    f = 0;
    for (int i = 0; i < NUM_TAGS; i++) if (!m_live[i]) f++;
    return f;
  endfunction

  // Checks that the registered outputs match the model state.
  task automatic check_regs(input string pfx);
    chk({pfx, "_mask"}, 32'(inflight_mask), 32'(model_mask()));
    chk({pfx, "_free"}, 32'(free_count), 32'(model_free()));
    chk({pfx, "_flush"}, 32'(flush), 32'(m_flush));
    chk({pfx, "_kill"}, 32'(kill_mask), 32'(m_kill));
`ifdef BRANCH_TAG_STATS_EN
    chk({pfx, "_stallcnt"}, 32'(stall_cycles), 32'(m_stall_cnt));
    chk({pfx, "_miscnt"}, 32'(mispredict_count), 32'(m_mis_cnt));
`endif
  endtask

  // One clock cycle: drive inputs, check, clock, then advance the model.
  task automatic cycle(input bit v1, input bit b1, input bit v2, input bit b2,
                       input bit rv, input int rtag, input bit rm);
    bit r1, r2, e_stall, e_tv1, e_tv2;
    int need, e_t1, e_t2, youngest;
    int free_q[$];
    dec_valid1 = v1; is_branch1 = b1; dec_valid2 = v2; is_branch2 = b2;
    resolve_valid = rv; resolve_tag = TAG_W'(rtag); resolve_mispredict = rm;
    #4;
    r1 = v1 & b1;
    r2 = v2 & b2;
    need = int'(r1) + int'(r2);
    e_stall = (need > model_free()) || (rv && rm);
    for (int i = 0; i < NUM_TAGS; i++) if (!m_live[i]) free_q.push_back(i);
    e_tv1 = r1 && !e_stall;
    e_tv2 = r2 && !e_stall;
    e_t1 = 0; e_t2 = 0;
    if (e_tv1) e_t1 = free_q[0];
    if (e_tv2) e_t2 = r1 ? free_q[1] : free_q[0];
    chk("stall", 32'(stall), 32'(e_stall));
    chk("tag_valid1", 32'(tag_valid1), 32'(e_tv1));
    chk("tag_valid2", 32'(tag_valid2), 32'(e_tv2));
    chk("tag1", 32'(tag1), 32'(e_t1));
    chk("tag2", 32'(tag2), 32'(e_t2));
    check_regs("reg");
    $display("cyc t=%0t req=%0d%0d res=%0d tag=%0d mis=%0d -> stall=%0d tv=%0d%0d tags=%0d,%0d mask=%b flush=%0d",
             $time, r1, r2, rv, rtag, rm, stall, tag_valid1, tag_valid2, tag1, tag2, inflight_mask, flush);
    @(posedge clk);
    #1;
    // Advance the model: resolve first (it uses the pre-allocation live set),
    // then commit the allocations.
    m_flush = 1'b0;
    m_kill  = '0;
    if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
    if (rv && rtag < NUM_TAGS && m_live[rtag]) begin
      if (!rm) begin
        m_live[rtag] = 1'b0;
      end else begin
        youngest = int'(m_seq[rtag]);
        for (int j = 0; j < NUM_TAGS; j++) begin
          if (m_live[j] && (j == rtag || m_seq[j] > m_seq[rtag])) begin
            m_kill[j] = 1'b1;
            m_live[j] = 1'b0;
          end
        end
        m_flush = 1'b1;
        if (m_mis_cnt < 65535) m_mis_cnt++;
      end
    end
    if (e_tv1) begin m_live[e_t1] = 1'b1; m_seq[e_t1] = m_ctr; m_ctr++; end
    if (e_tv2) begin m_live[e_t2] = 1'b1; m_seq[e_t2] = m_ctr; m_ctr++; end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    dec_valid1 = 0; dec_valid2 = 0; is_branch1 = 0; is_branch2 = 0;
    resolve_valid = 0; resolve_tag = '0; resolve_mispredict = 0;
    model_reset();
    #2;
    check_regs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Branch pair straight after reset: tags 0 and 1.
    cycle(1, 1, 1, 1, 0, 0, 0);
    chk("pair_mask_const", 32'(inflight_mask), 32'h3);
    chk("pair_free_const", 32'(free_count), 32'd2);

    // Fill the remaining tags, then slot 2 alone stalls while full.
    cycle(1, 1, 1, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("full_stall_const", 32'(stall), 32'd1);
    cycle(0, 0, 1, 1, 1, 1, 0);   // correct resolve of tag 1, still stalled
    cycle(0, 0, 1, 1, 0, 0, 0);   // slot 2 now receives tag 1
    chk("refill_mask_const", 32'(inflight_mask), 32'hF);

    // Drain everything, then allocate 0,1,2,3 and mispredict tag 1.
    cycle(0, 0, 0, 0, 1, 0, 1);
    idle();
    cycle(1, 1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 1);
    chk("mis_flush_const", 32'(flush), 32'd1);
    chk("mis_kill_const", 32'(kill_mask), 32'hE);
    chk("mis_mask_const", 32'(inflight_mask), 32'h1);
    idle();

    // Three live tags, so free_count=1: a pair stalls, slot 1 alone succeeds.
    cycle(1, 1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);

    // Mispredict on a tag that is not live: stall only, no flush.
    cycle(0, 0, 0, 0, 1, 0, 0);   // free tag 0 so tag 2... stays live
    cycle(0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 1, 1);   // tag 1 no longer live
    idle();

    // Build mask 1011, then assert reset asynchronously mid-cycle.
    cycle(0, 0, 0, 0, 1, 2, 0);
    cycle(1, 1, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 2, 0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_mask", 32'(inflight_mask), 32'h0);
    chk("arst_free", 32'(free_count), 32'd4);
    chk("arst_flush", 32'(flush), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit v1, b1, v2, b2, rv, rm;
      int rtag;
      v1 = ($urandom_range(0, 9) < 8);
      b1 = ($urandom_range(0, 9) < 6);
      v2 = ($urandom_range(0, 9) < 8);
      b2 = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 2) == 0);
      rtag = int'($urandom_range(0, NUM_TAGS - 1));
      rm = ($urandom_range(0, 4) == 0);
      cycle(v1, b1, v2, b2, rv, rtag, rm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
